mc_control: RTL and testbench

MC_CONTROL -- requirements
Module: mc_control

---
 rtl/mc_pkg.sv | 43 ++++
 rtl/mc_control_dec.sv | 130 +++++++++++++
 rtl/mc_control.sv | 99 +++++++++
 tb/tb_mc_control.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/mc_pkg.sv
// Shared types and encodings for the multicycle CPU control unit.
package mc_pkg;

  typedef enum logic [3:0] {
    S_START,
    S_FETCH,
    S_DECODE,
    S_MEMADR,
    S_MEMRD,
    S_MEMWB,
    S_MEMWR,
    S_EXEC,
    S_ALUWB,
    S_BRANCH,
    S_ADDIEX,
    S_ADDIWB,
    S_JUMP
  } state_t;

  localparam logic [3:0] OP_RTYPE = 4'b0000;
  localparam logic [3:0] OP_LW    = 4'b0001;
  localparam logic [3:0] OP_SW    = 4'b0010;
  localparam logic [3:0] OP_BEQ   = 4'b0011;
  localparam logic [3:0] OP_ADDI  = 4'b0100;
  localparam logic [3:0] OP_J     = 4'b0101;
  localparam logic [3:0] OP_BNE   = 4'b0110;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  localparam logic [1:0] SRCB_REGB   = 2'b00;
  localparam logic [1:0] SRCB_TWO    = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH = 2'b11;

  localparam logic [1:0] PC_ALU    = 2'b00;
  localparam logic [1:0] PC_ALUOUT = 2'b01;
  localparam logic [1:0] PC_JUMP   = 2'b10;

endpackage

// File: rtl/mc_control_dec.sv
// Moore output decode of the control FSM, plus instruction legality.
// Define MC_CONTROL_BNE_EN to decode opcode 0110 as BNE (branch on ~zero).
module mc_control_dec
  import mc_pkg::*;
#(
  parameter int OP_W = 4,
  parameter int FN_W = 3
) (
  input  state_t            state,
  input  logic [OP_W-1:0]   opcode,
  input  logic [FN_W-1:0]   funct,
  input  logic              zero,
  input  logic              mem_ready,
  output logic [2:0]        alu_op,
  output logic              alu_src_a,
  output logic [1:0]        alu_src_b,
  output logic [1:0]        pc_src,
  output logic              pc_en,
  output logic              ir_write,
  output logic              mem_read,
  output logic              mem_write,
  output logic              iord,
  output logic              reg_write,
  output logic              reg_dst,
  output logic              mem_to_reg,
  output logic              done,
  output logic              illegal
);

  logic decodable;
  logic branch_take;

  always_comb begin
    decodable = 1'b0;
    if (opcode == OP_W'(OP_RTYPE)) begin
      decodable = funct inside {FN_W'(ALU_AND), FN_W'(ALU_OR), FN_W'(ALU_ADD),
                                FN_W'(ALU_SUB), FN_W'(ALU_SLT)};
    end else if (opcode inside {OP_W'(OP_LW), OP_W'(OP_SW), OP_W'(OP_BEQ),
                                OP_W'(OP_ADDI), OP_W'(OP_J)}) begin
      decodable = 1'b1;
    end
`ifdef MC_CONTROL_BNE_EN
    else if (opcode == OP_W'(OP_BNE)) begin
      decodable = 1'b1;
    end
    branch_take = (opcode == OP_W'(OP_BNE)) ? ~zero : zero;
`else
    branch_take = zero;
`endif
  end

  always_comb begin
    // NOTE: every output gets a default before the case so no path can infer a latch.
    alu_op     = ALU_ADD;
    alu_src_a  = 1'b0;
    alu_src_b  = SRCB_REGB;
    pc_src     = PC_ALU;
    pc_en      = 1'b0;
    ir_write   = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    iord       = 1'b0;
    reg_write  = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    done       = 1'b0;
    illegal    = 1'b0;

    case (state)
      S_START: alu_op = 3'b000;
      S_FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = SRCB_TWO;
        ir_write  = mem_ready;
        pc_en     = mem_ready;
      end
      S_DECODE: begin
        alu_src_b = SRCB_IMM_SH;
        illegal   = ~decodable;
        done      = ~decodable;
      end
      S_MEMADR, S_ADDIEX: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
      end
      S_MEMRD: begin
        mem_read = 1'b1;
        iord     = 1'b1;
      end
      S_MEMWB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        done       = 1'b1;
      end
      S_MEMWR: begin
        mem_write = 1'b1;
        iord      = 1'b1;
        done      = mem_ready;
      end
      S_EXEC: begin
        alu_src_a = 1'b1;
        alu_op    = 3'(funct);
      end
      S_ALUWB: begin
        reg_write = 1'b1;
        reg_dst   = 1'b1;
        alu_op    = 3'(funct);
        done      = 1'b1;
      end
      S_BRANCH: begin
        alu_src_a = 1'b1;
        alu_op    = ALU_SUB;
        pc_src    = PC_ALUOUT;
        pc_en     = branch_take;
        done      = 1'b1;
      end
      S_ADDIWB: begin
        reg_write = 1'b1;
        done      = 1'b1;
      end
      S_JUMP: begin
        pc_src = PC_JUMP;
        pc_en  = 1'b1;
        done   = 1'b1;
      end
      default: alu_op = 3'b000;
    endcase
  end

endmodule

// File: rtl/mc_control.sv
// Multicycle CPU control unit: state register and next-state logic.
// BNE support follows MC_CONTROL_BNE_EN through the decode sub-module.
module mc_control
  import mc_pkg::*;
#(
  parameter int OP_W = 4,
  parameter int FN_W = 3
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic [OP_W-1:0] opcode,
  input  logic [FN_W-1:0] funct,
  input  logic            zero,
  input  logic            mem_ready,
  output logic [2:0]      alu_op,
  output logic            alu_src_a,
  output logic [1:0]      alu_src_b,
  output logic [1:0]      pc_src,
  output logic            pc_en,
  output logic            ir_write,
  output logic            mem_read,
  output logic            mem_write,
  output logic            iord,
  output logic            reg_write,
  output logic            reg_dst,
  output logic            mem_to_reg,
  output logic            done,
  output logic            illegal
);

  state_t state, state_nxt;
  logic   armed;

  // armed holds START for one extra edge so the first FETCH lands on the
  // second rising edge after reset release.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= S_START;
      armed <= 1'b0;
    end else begin
      // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
      state <= state_nxt;
      armed <= 1'b1;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_START:  state_nxt = armed ? S_FETCH : S_START;
      S_FETCH:  state_nxt = mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        state_nxt = S_FETCH;
        if (!illegal) begin
          case (opcode)
            OP_W'(OP_RTYPE):              state_nxt = S_EXEC;
            OP_W'(OP_LW), OP_W'(OP_SW):   state_nxt = S_MEMADR;
            OP_W'(OP_BEQ), OP_W'(OP_BNE): state_nxt = S_BRANCH;
            OP_W'(OP_ADDI):               state_nxt = S_ADDIEX;
            OP_W'(OP_J):                  state_nxt = S_JUMP;
            default:                      state_nxt = S_FETCH;
          endcase
        end
      end
      S_MEMADR: state_nxt = (opcode == OP_W'(OP_LW)) ? S_MEMRD : S_MEMWR;
      S_MEMRD:  state_nxt = mem_ready ? S_MEMWB : S_MEMRD;
      S_MEMWR:  state_nxt = mem_ready ? S_FETCH : S_MEMWR;
      S_EXEC:   state_nxt = S_ALUWB;
      S_ADDIEX: state_nxt = S_ADDIWB;
      default:  state_nxt = S_FETCH;
    endcase
  end

  mc_control_dec #(
    .OP_W(OP_W),
    .FN_W(FN_W)
  ) u_dec (
    .state      (state),
    .opcode     (opcode),
    .funct      (funct),
    .zero       (zero),
    .mem_ready  (mem_ready),
    .alu_op     (alu_op),
    .alu_src_a  (alu_src_a),
    .alu_src_b  (alu_src_b),
    .pc_src     (pc_src),
    .pc_en      (pc_en),
    .ir_write   (ir_write),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .iord       (iord),
    .reg_write  (reg_write),
    .reg_dst    (reg_dst),
    .mem_to_reg (mem_to_reg),
    .done       (done),
    .illegal    (illegal)
  );

endmodule

// File: tb/tb_mc_control.sv
// Scoreboard bench for mc_control: per-instruction timelines from a reference
// model are queued by the driver and compared cycle by cycle by a monitor.
`timescale 1ns/1ps
module tb_mc_control;

`ifdef MC_CONTROL_BNE_EN
  localparam bit BNE_ON = 1'b1;
`else
  localparam bit BNE_ON = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [3:0] opcode = '0;
  logic [2:0] funct = '0;
  logic       zero = 1'b0;
  logic       mem_ready = 1'b0;
  logic [2:0] alu_op;
  logic       alu_src_a;
  logic [1:0] alu_src_b, pc_src;
  logic       pc_en, ir_write, mem_read, mem_write, iord;
  logic       reg_write, reg_dst, mem_to_reg, done, illegal;

  always #5 clk = ~clk;

  mc_control dut (
    .clk(clk), .reset_n(reset_n), .opcode(opcode), .funct(funct),
    .zero(zero), .mem_ready(mem_ready), .alu_op(alu_op),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .pc_src(pc_src),
    .pc_en(pc_en), .ir_write(ir_write), .mem_read(mem_read),
    .mem_write(mem_write), .iord(iord), .reg_write(reg_write),
    .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .done(done),
    .illegal(illegal)
  );

  typedef struct packed {
    logic [2:0] alu_op;
    logic       a;
    logic [1:0] b;
    logic [1:0] pcs;
    logic       pc_en, ir_write, mem_read, mem_write, iord;
    logic       reg_write, reg_dst, mem_to_reg, done, illegal;
  } obs_t;

  obs_t  act;
  obs_t  exp_q[$];
  string tag_q[$];
  int    vectors = 0;
  int    miscompares = 0;

  assign act = {alu_op, alu_src_a, alu_src_b, pc_src, pc_en, ir_write,
                mem_read, mem_write, iord, reg_write, reg_dst, mem_to_reg,
                done, illegal};

  task automatic check(input string name, input obs_t a, input obs_t e);
    vectors++;
    if (a !== e) begin
      miscompares++;
      $display("FAIL %s @%0t: got %05h expected %05h", name, $time, a, e);
    end
  endtask

  initial begin : monitor
    obs_t  e;
    string t;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        t = tag_q.pop_front();
        check(t, act, e);
      end
    end
  end

  function automatic obs_t idle();
    obs_t o = '0;
    o.alu_op = 3'b010;
    return o;
  endfunction

  // One clock slot: drive inputs just after the edge and queue what the
  // outputs must show before the following edge.
  task automatic slot(input logic rst, input logic mr, input logic [3:0] op,
                      input logic [2:0] fn, input logic z, input obs_t e,
                      input string t);
    @(posedge clk);
    #1;
    reset_n   = rst;
    mem_ready = mr;
    opcode    = op;
    funct     = fn;
    zero      = z;
    exp_q.push_back(e);
    tag_q.push_back(t);
  endtask

  task automatic do_reset();
    for (int i = 0; i < 3; i++)
      slot(1'b0, 1'($urandom_range(0, 1)), 4'h0, 3'h0, 1'b0, '0, "reset");
    slot(1'b1, 1'b1, 4'h0, 3'h0, 1'b0, '0, "release");
    slot(1'b1, 1'b1, 4'h0, 3'h0, 1'b0, '0, "start");
  endtask

  // Reference timeline for one instruction. fw/mw are wait cycles in the
  // fetch and data-memory accesses; cut asserts reset inside a store.
  task automatic run_instr(input logic [3:0] op, input logic [2:0] fn,
                           input logic z, input int fw, input int mw,
                           input bit cut);
    obs_t e;
    bit   legal, bne;
    for (int i = 0; i <= fw; i++) begin
      e = idle();
      e.mem_read = 1'b1;
      e.b = 2'b01;
      e.ir_write = (i == fw);
      e.pc_en = (i == fw);
      slot(1'b1, (i == fw), op, fn, z, e, "fetch");
    end
    bne   = BNE_ON && (op == 4'h6);
    legal = (op inside {[4'h1:4'h5]}) || bne ||
            (op == 4'h0 && (fn inside {3'd0, 3'd1, 3'd2, 3'd6, 3'd7}));
    e = idle();
    e.b = 2'b11;
    e.illegal = !legal;
    e.done = !legal;
    slot(1'b1, 1'($urandom_range(0, 1)), op, fn, z, e, "decode");
    if (!legal) return;
    case (op)
      4'h0: begin
        e = idle(); e.a = 1'b1; e.alu_op = fn;
        slot(1'b1, 1'($urandom_range(0, 1)), op, fn, z, e, "exec");
        e = idle(); e.alu_op = fn; e.reg_write = 1'b1; e.reg_dst = 1'b1; e.done = 1'b1;
        slot(1'b1, 1'($urandom_range(0, 1)), op, fn, z, e, "aluwb");
      end
      4'h1, 4'h2: begin
        e = idle(); e.a = 1'b1; e.b = 2'b10;
        slot(1'b1, 1'($urandom_range(0, 1)), op, fn, z, e, "memadr");
        for (int i = 0; i <= mw; i++) begin
          if (cut && i == 1) begin
            slot(1'b0, 1'b0, op, fn, z, '0, "memwr_reset");
            return;
          end
          e = idle(); e.iord = 1'b1;
          if (op == 4'h1) e.mem_read = 1'b1;
          else begin
            e.mem_write = 1'b1;
            e.done = (i == mw);
          end
          slot(1'b1, (i == mw), op, fn, z, e, (op == 4'h1) ? "memrd" : "memwr");
        end
        if (op == 4'h1) begin
          e = idle(); e.reg_write = 1'b1; e.mem_to_reg = 1'b1; e.done = 1'b1;
          slot(1'b1, 1'($urandom_range(0, 1)), op, fn, z, e, "memwb");
        end
      end
      4'h3, 4'h6: begin
        e = idle(); e.a = 1'b1; e.alu_op = 3'b110; e.pcs = 2'b01;
        e.pc_en = bne ? !z : z; e.done = 1'b1;
        slot(1'b1, 1'($urandom_range(0, 1)), op, fn, z, e, "branch");
      end
      4'h4: begin
        e = idle(); e.a = 1'b1; e.b = 2'b10;
        slot(1'b1, 1'($urandom_range(0, 1)), op, fn, z, e, "addiex");
        e = idle(); e.reg_write = 1'b1; e.done = 1'b1;
        slot(1'b1, 1'($urandom_range(0, 1)), op, fn, z, e, "addiwb");
      end
      default: begin
        e = idle(); e.pcs = 2'b10; e.pc_en = 1'b1; e.done = 1'b1;
        slot(1'b1, 1'($urandom_range(0, 1)), op, fn, z, e, "jump");
      end
    endcase
  endtask

  initial begin : driver
    logic [3:0] op;
    int         pick;
    do_reset();
    run_instr(4'h0, 3'b010, 1'b0, 0, 0, 1'b0);
    run_instr(4'h1, 3'b000, 1'b0, 0, 2, 1'b0);
    run_instr(4'h3, 3'b000, 1'b1, 0, 0, 1'b0);
    run_instr(4'h3, 3'b000, 1'b0, 0, 0, 1'b0);
    run_instr(4'hF, 3'b000, 1'b0, 0, 0, 1'b0);
    run_instr(4'h0, 3'b011, 1'b0, 0, 0, 1'b0);
    run_instr(4'h6, 3'b000, 1'b0, 0, 0, 1'b0);
    run_instr(4'h2, 3'b000, 1'b0, 0, 3, 1'b1);
    do_reset();
    run_instr(4'h2, 3'b000, 1'b1, 1, 1, 1'b0);
    run_instr(4'h4, 3'b000, 1'b0, 2, 0, 1'b0);
    run_instr(4'h5, 3'b000, 1'b0, 0, 0, 1'b0);
    for (int n = 0; n < 250; n++) begin
      pick = $urandom_range(0, 8);
      op = (pick <= 6) ? 4'(pick) : 4'($urandom_range(7, 15));
      run_instr(op, 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                $urandom_range(0, 2), $urandom_range(0, 2), 1'b0);
    end
    repeat (3) @(posedge clk);
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: %0d expected cycles left unchecked, required 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
